// File: rtl/spi_slave_if_pkg.sv
// Shared constants for the SPI slave front end and its downstream command decoder.
package spi_slave_if_pkg;

  localparam int SPI_CPOL            = 0;
  localparam int SPI_CPHA            = 0;
  localparam bit SPI_MSB_FIRST       = 1'b1;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int BYTE_W              = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // Command byte layout seen by the transfer controller: bits[3:2] op, bits[1:0] channel.
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_op_e;

  function automatic cmd_op_e cmd_op(input logic [BYTE_W-1:0] cmd);
    return cmd_op_e'(cmd[3:2]);
  endfunction

  function automatic logic [1:0] cmd_channel(input logic [BYTE_W-1:0] cmd);
    return cmd[1:0];
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the byte-level handshake toward the transfer controller.
interface spi_slave_if_if;

  logic                                spi_sclk;
  logic                                spi_cs_n;
  logic                                spi_mosi;
  logic                                spi_miso;
  logic [spi_slave_if_pkg::BYTE_W-1:0] tx_byte;
  logic [spi_slave_if_pkg::BYTE_W-1:0] rx_byte;
  logic                                spi_cycle_done;
  logic                                busy;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_byte,
    output spi_miso, rx_byte, spi_cycle_done, busy
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_byte,
    input  spi_miso, rx_byte, spi_cycle_done, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with rise/fall pulses
// derived from the synchronized value and its one-cycle-delayed copy.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= {STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], din};
      prev_reg  <= stage_reg[STAGES-1];
    end
  end

  assign sync = stage_reg[STAGES-1];
  assign rise = stage_reg[STAGES-1] & ~prev_reg;
  assign fall = ~stage_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave byte engine: oversamples the SPI pins in the clk domain,
// shifts bytes MSB first and hands complete bytes to the transfer controller.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.spi_sclk),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.spi_cs_n),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi only needs its level; it stays aligned with sclk because both use the same depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_reg <= '0;
    else      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

  spi_state_e        state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [BYTE_W-1:0] rx_shift_reg, rx_shift_next;
  logic [BYTE_W-1:0] rx_byte_reg, rx_byte_next;
  logic [BYTE_W-1:0] tx_shift_reg, tx_shift_next;
  logic              load_pending_reg, load_pending_next;
  logic              byte_done_reg, byte_done_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= 3'd0;
      rx_shift_reg     <= '0;
      rx_byte_reg      <= '0;
      tx_shift_reg     <= '0;
      load_pending_reg <= 1'b0;
      byte_done_reg    <= 1'b0;
      done_reg         <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      rx_byte_reg      <= rx_byte_next;
      tx_shift_reg     <= tx_shift_next;
      load_pending_reg <= load_pending_next;
      byte_done_reg    <= byte_done_next;
      done_reg         <= done_next;
      busy_reg         <= busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    rx_byte_next      = rx_byte_reg;
    tx_shift_next     = tx_shift_reg;
    load_pending_next = load_pending_reg;
    byte_done_next    = 1'b0;
    busy_next         = busy_reg;
    // Delaying done by one cycle guarantees rx_byte is already stable when it rises.
    done_next         = byte_done_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next        = ST_ACTIVE;
          bit_cnt_next      = 3'd0;
          rx_shift_next     = '0;
          tx_shift_next     = bus.tx_byte;
          load_pending_next = 1'b0;
          busy_next         = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // Abort wins over any coincident sclk edge; the partial byte is dropped.
          state_next        = ST_IDLE;
          bit_cnt_next      = 3'd0;
          rx_shift_next     = '0;
          load_pending_next = 1'b0;
          busy_next         = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[BYTE_W-2:0], mosi_sync};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_byte_next      = {rx_shift_reg[BYTE_W-2:0], mosi_sync};
            load_pending_next = 1'b1;
            byte_done_next    = 1'b1;
          end
        end else if (sclk_fall) begin
          if (load_pending_reg) begin
            tx_shift_next     = bus.tx_byte;
            load_pending_next = 1'b0;
          end else begin
            tx_shift_next = {tx_shift_reg[BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.spi_miso       = (state_reg == ST_ACTIVE) ? tx_shift_reg[BYTE_W-1] : 1'b0;
  assign bus.rx_byte        = rx_byte_reg;
  assign bus.spi_cycle_done = done_reg;
  assign bus.busy           = busy_reg;

  // The synchronized sclk/cs levels are consumed through their edge pulses only.
  logic unused_sync;
  assign unused_sync = sclk_sync ^ cs_sync;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a table of single-byte transactions plus
// hand-written back-to-back, abort and mid-byte reset sequences.
module tb_spi_slave_if;

  localparam int HALF_CLKS = 8;

  logic clk;
  logic rst;

  spi_slave_if_if bus ();

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Pulse monitor: counts done pulses, high cycles, and rx_byte seen at each pulse.
  int         pulse_cnt = 0;
  int         hi_cnt    = 0;
  logic       done_d    = 1'b0;
  logic [7:0] pulse_rx_hist [8];

  always @(negedge clk) begin
    if (bus.spi_cycle_done && !done_d) begin
      pulse_rx_hist[pulse_cnt % 8] = bus.rx_byte;
      pulse_cnt = pulse_cnt + 1;
    end
    if (bus.spi_cycle_done) hi_cnt = hi_cnt + 1;
    done_d = bus.spi_cycle_done;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic half_bit();
    repeat (HALF_CLKS) @(negedge clk);
  endtask

  // Mode 0: mosi set while sclk low, master samples miso on the sclk rising edge.
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mo[7-i];
      half_bit();
      bus.spi_sclk = 1'b1;
      mi[7-i] = bus.spi_miso;
      half_bit();
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    bus.spi_cs_n = 1'b0;
    half_bit();
  endtask

  task automatic cs_end();
    half_bit();
    bus.spi_cs_n = 1'b1;
    half_bit();
  endtask

  typedef struct {
    string      name;
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0] mi, mi1, mi2, mi3;
    int p0;

    vecs[0] = '{"a5_3c", 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{"00_ff", 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{"ff_00", 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{"5a_81", 8'h5A, 8'h81, 8'h5A, 8'h81};

    rst          = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_byte  = 8'h00;
    repeat (4) @(negedge clk);
    check("reset_rx_byte", {24'd0, bus.rx_byte}, 32'h00);
    check("reset_done", {31'd0, bus.spi_cycle_done}, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'h0);
    check("reset_miso", {31'd0, bus.spi_miso}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // sclk activity with cs_n high must be ignored.
    p0 = pulse_cnt;
    xfer_bits(8'hFF, 8, mi);
    check("idle_no_pulse", pulse_cnt - p0, 0);
    check("idle_busy", {31'd0, bus.busy}, 32'h0);
    check("idle_miso", {24'd0, mi}, 32'h00);

    for (int v = 0; v < 4; v++) begin
      bus.tx_byte = vecs[v].tx;
      p0 = pulse_cnt;
      cs_begin();
      check({vecs[v].name, "_busy"}, {31'd0, bus.busy}, 32'h1);
      xfer_bits(vecs[v].mosi, 8, mi);
      cs_end();
      check({vecs[v].name, "_rx"}, {24'd0, bus.rx_byte}, {24'd0, vecs[v].exp_rx});
      check({vecs[v].name, "_miso"}, {24'd0, mi}, {24'd0, vecs[v].exp_miso});
      check({vecs[v].name, "_pulses"}, pulse_cnt - p0, 1);
      check({vecs[v].name, "_rx_at_pulse"}, {24'd0, pulse_rx_hist[p0 % 8]}, {24'd0, vecs[v].exp_rx});
      check({vecs[v].name, "_busy_after"}, {31'd0, bus.busy}, 32'h0);
      $display("vector %s: mosi=0x%02h rx=0x%02h miso=0x%02h", vecs[v].name, vecs[v].mosi, bus.rx_byte, mi);
    end

    // Back-to-back bytes with cs_n held low; tx_byte swapped after the first pulse.
    bus.tx_byte = 8'hAA;
    p0 = pulse_cnt;
    cs_begin();
    fork
      begin
        xfer_bits(8'h11, 8, mi1);
        xfer_bits(8'h22, 8, mi2);
        xfer_bits(8'h33, 8, mi3);
      end
      begin
        for (int k = 0; k < 400 && pulse_cnt == p0; k++) @(negedge clk);
        bus.tx_byte = 8'h55;
      end
    join
    cs_end();
    check("b2b_pulses", pulse_cnt - p0, 3);
    check("b2b_rx0", {24'd0, pulse_rx_hist[p0 % 8]}, 32'h11);
    check("b2b_rx1", {24'd0, pulse_rx_hist[(p0 + 1) % 8]}, 32'h22);
    check("b2b_rx2", {24'd0, pulse_rx_hist[(p0 + 2) % 8]}, 32'h33);
    check("b2b_miso0", {24'd0, mi1}, 32'hAA);
    check("b2b_miso1", {24'd0, mi2}, 32'h55);
    $display("back-to-back: rx=0x%02h miso=0x%02h/0x%02h/0x%02h", bus.rx_byte, mi1, mi2, mi3);

    // Abort after 5 bits, then a clean 0x81 transaction.
    p0 = pulse_cnt;
    cs_begin();
    xfer_bits(8'hF0, 5, mi);
    cs_end();
    check("abort_no_pulse", pulse_cnt - p0, 0);
    check("abort_rx_hold", {24'd0, bus.rx_byte}, 32'h33);
    check("abort_busy", {31'd0, bus.busy}, 32'h0);
    cs_begin();
    xfer_bits(8'h81, 8, mi);
    cs_end();
    check("after_abort_rx", {24'd0, bus.rx_byte}, 32'h81);
    check("after_abort_pulses", pulse_cnt - p0, 1);
    $display("abort then 0x81: rx=0x%02h", bus.rx_byte);

    // Reset after 4 bits, then a clean 0xC3 transaction.
    bus.tx_byte = 8'h00;
    p0 = pulse_cnt;
    cs_begin();
    xfer_bits(8'hC3, 4, mi);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rx", {24'd0, bus.rx_byte}, 32'h00);
    check("midrst_done", {31'd0, bus.spi_cycle_done}, 32'h0);
    check("midrst_busy", {31'd0, bus.busy}, 32'h0);
    check("midrst_miso", {31'd0, bus.spi_miso}, 32'h0);
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    cs_begin();
    xfer_bits(8'hC3, 8, mi);
    cs_end();
    check("post_rst_rx", {24'd0, bus.rx_byte}, 32'hC3);
    check("post_rst_pulses", pulse_cnt - p0, 1);
    $display("reset then 0xC3: rx=0x%02h", bus.rx_byte);

    check("done_one_cycle", hi_cnt, pulse_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
